vector_uop_sequencer: RTL and testbench

Consumes the active vector configuration (vsew, vlmul, vl, vill) and one decoded vector instruction (vs1/vs2/vd base registers). Expands the instruction into one micro-op per physical vector register of the register group.
Each micro-op carries its register indices, the base index of its first element, and a per-byte enable mask for tail/body elements. Micro-ops are handed to the vector execute lane over a valid/ready handshake.
Sits between the vector configuration CSR stage and the vector ALU/LSU lane.

---
 rtl/RS5_pkg.sv | 47 ++++
 rtl/vector_byte_en_gen.sv | 28 ++
 rtl/vector_uop_sequencer.sv | 169 ++++++++++++++++
 tb/tb_vector_uop_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/RS5_pkg.sv
// Shared vector types for the RS5 core slice used by the micro-op sequencer.
// Holds the vector configuration encodings, the sequencer state type and the
// bundle describing one issued micro-op.
package RS5_pkg;

  // Element width as encoded in vtype.vsew.
  typedef enum logic [1:0] {
    EW8  = 2'd0,
    EW16 = 2'd1,
    EW32 = 2'd2,
    EW64 = 2'd3
  } vew_e;

  // Register group multiplier as encoded in vtype.vlmul; 4 is reserved.
  typedef enum logic [2:0] {
    LMUL_1        = 3'd0,
    LMUL_2        = 3'd1,
    LMUL_4        = 3'd2,
    LMUL_8        = 3'd3,
    LMUL_RESERVED = 3'd4,
    LMUL_F8       = 3'd5,
    LMUL_F4       = 3'd6,
    LMUL_F2       = 3'd7
  } vlmul_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    FINISH = 2'd2
  } uopSeqState_e;

  // Default vector geometry; the micro-op bundle is sized from these.
  localparam int VLEN_DEFAULT  = 64;
  localparam int VLENB_DEFAULT = VLEN_DEFAULT / 8;
  localparam int VL_W_DEFAULT  = $clog2(VLEN_DEFAULT) + 1;

  typedef struct packed {
    logic [4:0]               vs1;
    logic [4:0]               vs2;
    logic [4:0]               vd;
    logic [VL_W_DEFAULT-1:0]  elem_base;
    logic [VLENB_DEFAULT-1:0] byte_en;
    logic                     first;
    logic                     last;
  } vectorUop_t;

endpackage

// File: rtl/vector_byte_en_gen.sv
// Combinational element-base and byte-enable generator for one physical
// register of a group: byte b is live when its element index is below vl.
module vector_byte_en_gen
  import RS5_pkg::*;
#(
  parameter  int VLEN  = VLEN_DEFAULT,
  localparam int VLENB = VLEN / 8,
  localparam int VL_W  = $clog2(VLEN) + 1
) (
  input  logic [VL_W-1:0]  i_k,
  input  vew_e             i_vsew,
  input  logic [VL_W-1:0]  i_vl,
  output logic [VL_W-1:0]  o_elem_base,
  output logic [VLENB-1:0] o_byte_en
);

  logic [VL_W-1:0] w_epr;
  logic [VL_W-1:0] w_base;

  assign w_epr       = VL_W'(VLENB) >> i_vsew;
  assign w_base      = i_k * w_epr;
  assign o_elem_base = w_base;

  for (genvar b = 0; b < VLENB; b++) begin : g_byte
    assign o_byte_en[b] = (w_base + (VL_W'(b) >> i_vsew)) < i_vl;
  end

endmodule

// File: rtl/vector_uop_sequencer.sv
// Expands one decoded vector instruction into one micro-op per physical
// register of its group and hands them to the execute lane over valid/ready.
// All configuration is captured at start so later input changes cannot
// disturb an instruction in flight.
module vector_uop_sequencer
  import RS5_pkg::*;
#(
  parameter  int VLEN  = VLEN_DEFAULT,
  localparam int VLENB = VLEN / 8,
  localparam int VL_W  = $clog2(VLEN) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  vew_e             vsew_i,
  input  vlmul_e           vlmul_i,
  input  logic [VL_W-1:0]  vl_i,
  input  logic             vill_i,
  input  logic [4:0]       vs1_i,
  input  logic [4:0]       vs2_i,
  input  logic [4:0]       vd_i,
  output logic             busy_o,
  output logic             uop_valid_o,
  input  logic             uop_ready_i,
  output logic [4:0]       uop_vs1_o,
  output logic [4:0]       uop_vs2_o,
  output logic [4:0]       uop_vd_o,
  output logic [VL_W-1:0]  uop_elem_base_o,
  output logic [VLENB-1:0] uop_byte_en_o,
  output logic             uop_first_o,
  output logic             uop_last_o,
  output logic             done_o,
  output logic             illegal_o
);

  localparam int LOG2_VLENB = $clog2(VLENB);

  uopSeqState_e    r_state;
  logic [4:0]      r_vs1, r_vs2, r_vd;
  vew_e            r_vsew;
  logic [VL_W-1:0] r_vl;
  logic [VL_W-1:0] r_k;
  logic [VL_W-1:0] r_n_m1;
  logic            r_illegal;

  logic            w_cfg_illegal;
  logic [VL_W:0]   w_epr_in;
  logic [7:0]      w_shamt;
  logic [VL_W:0]   w_ceil;
  logic [VL_W:0]   w_group;
  logic [VL_W:0]   w_n;
  logic            w_issue;
  logic            w_last;
  logic [VL_W-1:0] w_elem_base;
  logic [VLENB-1:0] w_byte_en;
  vectorUop_t      w_uop;
  vectorUop_t      w_uop_out;

  assign w_cfg_illegal = vill_i | (vlmul_i == LMUL_RESERVED);

  // Micro-op count from the incoming config: ceil(vl/EPR) clipped to the group size.
  assign w_epr_in = (VL_W+1)'(VLENB) >> vsew_i;
  assign w_shamt  = 8'(LOG2_VLENB) - 8'(vsew_i);
  assign w_ceil   = ({1'b0, vl_i} + w_epr_in - (VL_W+1)'(1)) >> w_shamt;

  // Fractional multipliers still occupy a single physical register.
  always_comb begin
    w_group = (VL_W+1)'(1);
    case (vlmul_i)
      LMUL_2:  w_group = (VL_W+1)'(2);
      LMUL_4:  w_group = (VL_W+1)'(4);
      LMUL_8:  w_group = (VL_W+1)'(8);
      default: w_group = (VL_W+1)'(1);
    endcase
  end

  assign w_n = (w_ceil < w_group) ? w_ceil : w_group;

  assign w_issue = (r_state == ISSUE);
  assign w_last  = (r_k == r_n_m1);

  vector_byte_en_gen #(.VLEN(VLEN)) u_byte_en (
    .i_k         (r_k),
    .i_vsew      (r_vsew),
    .i_vl        (r_vl),
    .o_elem_base (w_elem_base),
    .o_byte_en   (w_byte_en)
  );

  // Assemble the current micro-op from the latched instruction and index k.
  always_comb begin
    w_uop           = '0;
    w_uop.vs1       = r_vs1 + r_k[4:0];
    w_uop.vs2       = r_vs2 + r_k[4:0];
    w_uop.vd        = r_vd + r_k[4:0];
    w_uop.elem_base = w_elem_base;
    w_uop.byte_en   = w_byte_en;
    w_uop.first     = (r_k == '0);
    w_uop.last      = w_last;
  end

  // Payload is forced to zero whenever no micro-op is being offered.
  assign w_uop_out = w_issue ? w_uop : '0;

  assign uop_valid_o     = w_issue;
  assign uop_vs1_o       = w_uop_out.vs1;
  assign uop_vs2_o       = w_uop_out.vs2;
  assign uop_vd_o        = w_uop_out.vd;
  assign uop_elem_base_o = w_uop_out.elem_base;
  assign uop_byte_en_o   = w_uop_out.byte_en;
  assign uop_first_o     = w_uop_out.first;
  assign uop_last_o      = w_uop_out.last;
  assign busy_o          = (r_state != IDLE);
  assign done_o          = (r_state == FINISH);
  assign illegal_o       = r_illegal;

  // Sequencer state, latched instruction and micro-op index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_vs1     <= '0;
      r_vs2     <= '0;
      r_vd      <= '0;
      r_vsew    <= EW8;
      r_vl      <= '0;
      r_k       <= '0;
      r_n_m1    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_vs1  <= vs1_i;
            r_vs2  <= vs2_i;
            r_vd   <= vd_i;
            r_vsew <= vsew_i;
            r_vl   <= vl_i;
            r_k    <= '0;
            r_n_m1 <= VL_W'(w_n - (VL_W+1)'(1));
            if (w_cfg_illegal) begin
              r_illegal <= 1'b1;
            end else if (vl_i == '0) begin
              r_state <= FINISH;
            end else begin
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (uop_ready_i) begin
            if (w_last) begin
              r_state <= FINISH;
            end else begin
              r_k <= r_k + VL_W'(1);
            end
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_uop_sequencer.sv
// Directed bench for vector_uop_sequencer with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_vector_uop_sequencer;
  import RS5_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       start_i;
  vew_e       vsew_i;
  vlmul_e     vlmul_i;
  logic [6:0] vl_i;
  logic       vill_i;
  logic [4:0] vs1_i, vs2_i, vd_i;
  logic       busy_o, uop_valid_o, uop_ready_i;
  logic [4:0] uop_vs1_o, uop_vs2_o, uop_vd_o;
  logic [6:0] uop_elem_base_o;
  logic [7:0] uop_byte_en_o;
  logic       uop_first_o, uop_last_o, done_o, illegal_o;

  int n_tests = 0;
  int n_fail  = 0;

  vector_uop_sequencer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start_i         (start_i),
    .vsew_i          (vsew_i),
    .vlmul_i         (vlmul_i),
    .vl_i            (vl_i),
    .vill_i          (vill_i),
    .vs1_i           (vs1_i),
    .vs2_i           (vs2_i),
    .vd_i            (vd_i),
    .busy_o          (busy_o),
    .uop_valid_o     (uop_valid_o),
    .uop_ready_i     (uop_ready_i),
    .uop_vs1_o       (uop_vs1_o),
    .uop_vs2_o       (uop_vs2_o),
    .uop_vd_o        (uop_vd_o),
    .uop_elem_base_o (uop_elem_base_o),
    .uop_byte_en_o   (uop_byte_en_o),
    .uop_first_o     (uop_first_o),
    .uop_last_o      (uop_last_o),
    .done_o          (done_o),
    .illegal_o       (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_uop(input string tag, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic [6:0] base, input logic [7:0] be,
                         input logic f, input logic l);
    chk({tag, ".valid"}, uop_valid_o, 1);
    chk({tag, ".vs1"}, uop_vs1_o, s1);
    chk({tag, ".vs2"}, uop_vs2_o, s2);
    chk({tag, ".vd"}, uop_vd_o, d);
    chk({tag, ".base"}, uop_elem_base_o, base);
    chk({tag, ".be"}, uop_byte_en_o, be);
    chk({tag, ".first"}, uop_first_o, f);
    chk({tag, ".last"}, uop_last_o, l);
  endtask

  task automatic set_cmd(input vew_e sew, input vlmul_e lmul, input logic [6:0] vl,
                         input logic vill, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d);
    start_i = 1'b1;
    vsew_i  = sew;
    vlmul_i = lmul;
    vl_i    = vl;
    vill_i  = vill;
    vs1_i   = s1;
    vs2_i   = s2;
    vd_i    = d;
  endtask

  logic [7:0] be2 [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h0F};
  int         seen_done;

  initial begin
    reset_n     = 1'b0;
    start_i     = 1'b0;
    vsew_i      = EW8;
    vlmul_i     = LMUL_1;
    vl_i        = '0;
    vill_i      = 1'b0;
    vs1_i       = '0;
    vs2_i       = '0;
    vd_i        = '0;
    uop_ready_i = 1'b1;
    #1;
    chk("rst.busy", busy_o, 0);
    chk("rst.valid", uop_valid_o, 0);
    chk("rst.done", done_o, 0);
    chk("rst.illegal", illegal_o, 0);
    chk("rst.first", uop_first_o, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: single micro-op, EW8 LMUL_1 vl=5
    set_cmd(EW8, LMUL_1, 7'd5, 1'b0, 5'd0, 5'd0, 5'd4);
    @(negedge clk);
    start_i = 1'b0;
    chk_uop("c1.u0", 5'd0, 5'd0, 5'd4, 7'd0, 8'h1F, 1, 1);
    chk("c1.busy_t1", busy_o, 1);
    @(negedge clk);
    chk("c1.done", done_o, 1);
    chk("c1.valid_off", uop_valid_o, 0);
    chk("c1.busy_fin", busy_o, 1);
    @(negedge clk);
    chk("c1.busy_low", busy_o, 0);
    chk("c1.done_low", done_o, 0);

    // 2: EW32 LMUL_4 vl=7; inputs disturbed after start
    set_cmd(EW32, LMUL_4, 7'd7, 1'b0, 5'd1, 5'd8, 5'd16);
    @(negedge clk);
    start_i = 1'b0;
    vl_i    = 7'd0;
    vsew_i  = EW8;
    for (int k = 0; k < 4; k++) begin
      chk_uop($sformatf("c2.u%0d", k), 5'(1 + k), 5'(8 + k), 5'(16 + k), 7'(2 * k),
              be2[k], k == 0, k == 3);
      @(negedge clk);
    end
    chk("c2.done", done_o, 1);
    @(negedge clk);
    chk("c2.busy_low", busy_o, 0);

    // 3: as case 2 with a 3-cycle stall at k=1 and a stray start during it
    set_cmd(EW32, LMUL_4, 7'd7, 1'b0, 5'd1, 5'd8, 5'd16);
    @(negedge clk);
    start_i = 1'b0;
    chk_uop("c3.u0", 5'd1, 5'd8, 5'd16, 7'd0, 8'hFF, 1, 0);
    @(negedge clk);
    uop_ready_i = 1'b0;
    start_i     = 1'b1;
    for (int s = 0; s < 3; s++) begin
      chk_uop($sformatf("c3.stall%0d", s), 5'd2, 5'd9, 5'd17, 7'd2, 8'hFF, 0, 0);
      @(negedge clk);
    end
    start_i     = 1'b0;
    uop_ready_i = 1'b1;
    chk_uop("c3.u1", 5'd2, 5'd9, 5'd17, 7'd2, 8'hFF, 0, 0);
    @(negedge clk);
    chk_uop("c3.u2", 5'd3, 5'd10, 5'd18, 7'd4, 8'hFF, 0, 0);
    @(negedge clk);
    chk_uop("c3.u3", 5'd4, 5'd11, 5'd19, 7'd6, 8'h0F, 0, 1);
    @(negedge clk);
    chk("c3.done", done_o, 1);
    chk("c3.valid_off", uop_valid_o, 0);
    @(negedge clk);
    chk("c3.not_queued", busy_o, 0);
    chk("c3.no_valid", uop_valid_o, 0);

    // 4: vl=0 goes straight to FINISH without any micro-op
    set_cmd(EW16, LMUL_2, 7'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    start_i = 1'b0;
    chk("c4.valid", uop_valid_o, 0);
    chk("c4.done", done_o, 1);
    chk("c4.busy", busy_o, 1);
    @(negedge clk);
    chk("c4.busy_low", busy_o, 0);
    chk("c4.done_low", done_o, 0);
    chk("c4.valid_low", uop_valid_o, 0);

    // 5: vill, then reserved vlmul back-to-back, then a legal start
    set_cmd(EW8, LMUL_1, 7'd8, 1'b1, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    chk("c5.ill_vill", illegal_o, 1);
    chk("c5.valid_vill", uop_valid_o, 0);
    chk("c5.busy_vill", busy_o, 0);
    chk("c5.done_vill", done_o, 0);
    set_cmd(EW8, LMUL_RESERVED, 7'd8, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    chk("c5.ill_lmul", illegal_o, 1);
    chk("c5.valid_lmul", uop_valid_o, 0);
    chk("c5.done_lmul", done_o, 0);
    set_cmd(EW8, LMUL_1, 7'd8, 1'b0, 5'd0, 5'd0, 5'd3);
    @(negedge clk);
    start_i = 1'b0;
    chk("c5.ill_clear", illegal_o, 0);
    chk_uop("c5.u0", 5'd0, 5'd0, 5'd3, 7'd0, 8'hFF, 1, 1);
    @(negedge clk);
    chk("c5.done", done_o, 1);
    @(negedge clk);

    // 6: LMUL_8 with vd wrap, reset after two handshakes
    set_cmd(EW8, LMUL_8, 7'd64, 1'b0, 5'd0, 5'd0, 5'd30);
    @(negedge clk);
    start_i = 1'b0;
    chk_uop("c6.u0", 5'd0, 5'd0, 5'd30, 7'd0, 8'hFF, 1, 0);
    @(negedge clk);
    chk_uop("c6.u1", 5'd1, 5'd1, 5'd31, 7'd8, 8'hFF, 0, 0);
    @(negedge clk);
    chk_uop("c6.u2", 5'd2, 5'd2, 5'd0, 7'd16, 8'hFF, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("c6.rst_valid", uop_valid_o, 0);
    chk("c6.rst_busy", busy_o, 0);
    chk("c6.rst_done", done_o, 0);
    chk("c6.rst_illegal", illegal_o, 0);
    chk("c6.rst_vd", uop_vd_o, 0);
    chk("c6.rst_be", uop_byte_en_o, 0);
    chk("c6.rst_base", uop_elem_base_o, 0);
    chk("c6.rst_first", uop_first_o, 0);
    @(negedge clk);
    reset_n   = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done_o || busy_o || illegal_o) seen_done++;
    end
    chk("c6.post_rst_quiet", seen_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
